a_fifo: RTL and testbench

A_FIFO -- requirements
Module: a_fifo

---
 rtl/a_fifo_if.sv | 25 ++
 rtl/a_fifo.sv | 101 ++++++++++
 tb/tb_a_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/a_fifo_if.sv
// rtl/a_fifo_if.sv - write/read/status signal bundle for a_fifo
interface a_fifo_if #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 8
);
  logic [WIDTH-1:0]  data;
  logic              wrreq;
  logic              rdreq;
  logic [WIDTH-1:0]  q;
  logic [ADDR_W-1:0] usedw;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, usedw, empty, full, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, usedw, empty, full, overflow, underflow
  );
endinterface

// File: rtl/a_fifo.sv
// rtl/a_fifo.sv - single-clock sample FIFO, registered non-show-ahead read, sticky error flags
// Optional A_FIFO_UNDERRUN_ZERO_EN: a rejected read loads q with zero instead of holding it.
module a_fifo #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  a_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [ADDR_W-1:0] usedw_q, usedw_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              rd_acc;
  logic              wr_acc;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = bus.rdreq && !empty_q;
  assign wr_acc = bus.wrreq && (!full_q || rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    q_d         = q_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end
    if (bus.wrreq && !wr_acc) begin
      overflow_d = 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
      q_d      = mem[rd_ptr_q[ADDR_W-1:0]];
    end else if (bus.rdreq) begin
      underflow_d = 1'b1;
`ifdef A_FIFO_UNDERRUN_ZERO_EN
      q_d = '0;
`else
      q_d = q_q;
`endif
    end

    // Flags track the pointers as they will be after this edge.
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    usedw_d = wr_ptr_d[ADDR_W-1:0] - rd_ptr_d[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      q_q         <= '0;
      usedw_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      q_q         <= q_d;
      usedw_q     <= usedw_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left uncleared by reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= bus.data;
    end
  end

  assign bus.q         = q_q;
  assign bus.usedw     = usedw_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_a_fifo.sv
// tb/tb_a_fifo.sv - directed self-checking bench for a_fifo
module tb_a_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  a_fifo_if #(.WIDTH(24), .ADDR_W(8)) bus ();

  a_fifo #(.WIDTH(24), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [23:0] d);
    bus.wrreq = wr;
    bus.rdreq = rd;
    bus.data  = d;
  endtask

  task automatic check_flags(input string tag, input int usedw, input bit empty, input bit full);
    check({tag, "_usedw"}, {24'd0, bus.usedw}, usedw);
    check({tag, "_empty"}, {31'd0, bus.empty}, {31'd0, empty});
    check({tag, "_full"},  {31'd0, bus.full},  {31'd0, full});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] exp_q;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 24'd0);
    step();
    step();
    rst = 1'b0;

    check_flags("reset", 0, 1'b1, 1'b0);
    check("reset_q", {8'd0, bus.q}, 32'd0);
    check("reset_ovf", {31'd0, bus.overflow}, 32'd0);
    check("reset_unf", {31'd0, bus.underflow}, 32'd0);

    // Three writes then three reads
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 24'(i));
      step();
    end
    drive(1'b0, 1'b0, 24'd0);
    check_flags("wr3", 3, 1'b0, 1'b0);
    step();
    check("hold_q", {8'd0, bus.q}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 24'd0);
      step();
      check($sformatf("rd3_q%0d", i), {8'd0, bus.q}, 32'(i));
      check($sformatf("rd3_usedw%0d", i), {24'd0, bus.usedw}, 32'(3 - i));
    end
    drive(1'b0, 1'b0, 24'd0);
    check("rd3_empty", {31'd0, bus.empty}, 32'd1);

    // Underrun after q = 0x123456
    drive(1'b1, 1'b0, 24'h123456);
    step();
    drive(1'b0, 1'b1, 24'd0);
    step();
    check("unf_lastq", {8'd0, bus.q}, 32'h123456);
    check("unf_pre", {31'd0, bus.underflow}, 32'd0);
    step();
    drive(1'b0, 1'b0, 24'd0);
    check("unf_set", {31'd0, bus.underflow}, 32'd1);
`ifdef A_FIFO_UNDERRUN_ZERO_EN
    check("unf_q", {8'd0, bus.q}, 32'h000000);
`else
    check("unf_q", {8'd0, bus.q}, 32'h123456);
`endif
    check_flags("unf", 0, 1'b1, 1'b0);
    step();
    check("unf_sticky", {31'd0, bus.underflow}, 32'd1);

    // Fill to 256, wrap with simultaneous traffic, then overflow
    do_reset();
    check("rst_unf_clr", {31'd0, bus.underflow}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 24'(i));
      step();
      if (i == 254) check_flags("fill255", 255, 1'b0, 1'b0);
    end
    check_flags("fill256", 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 24'(1000 + i));
      step();
      check($sformatf("wrap_q%0d", i), {8'd0, bus.q}, 32'(i));
      check($sformatf("wrap_full%0d", i), {31'd0, bus.full}, 32'd1);
    end
    check("wrap_no_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(1'b1, 1'b0, 24'hABCDEF);
    step();
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check_flags("ovf", 0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 24'd0);
      step();
      exp_q = (i < 246) ? 24'(i + 10) : 24'(1000 + i - 246);
      check($sformatf("drain_q%0d", i), {8'd0, bus.q}, {8'd0, exp_q});
    end
    drive(1'b0, 1'b0, 24'd0);
    check_flags("drain", 0, 1'b1, 1'b0);
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    check("drain_no_unf", {31'd0, bus.underflow}, 32'd0);

    // Simultaneous write/read on empty
    do_reset();
    drive(1'b1, 1'b1, 24'h7FFFFF);
    step();
    drive(1'b0, 1'b0, 24'd0);
    check_flags("wrrd_empty", 1, 1'b0, 1'b0);
    check("wrrd_unf", {31'd0, bus.underflow}, 32'd1);
    drive(1'b0, 1'b1, 24'd0);
    step();
    drive(1'b0, 1'b0, 24'd0);
    check("wrrd_q", {8'd0, bus.q}, 32'h7FFFFF);
    check_flags("wrrd_after", 0, 1'b1, 1'b0);

    // Reset mid-operation with 100 stored words
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 24'(24'h300000 + i));
      step();
    end
    drive(1'b0, 1'b1, 24'd0);
    step();
    check("pre_rst_q", {8'd0, bus.q}, 32'h300000);
    drive(1'b1, 1'b1, 24'h111111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_flags("midrst", 0, 1'b1, 1'b0);
    check("midrst_q", {8'd0, bus.q}, 32'd0);
    check("midrst_unf", {31'd0, bus.underflow}, 32'd0);
    check("midrst_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(1'b1, 1'b0, 24'h55AA55);
    step();
    check_flags("post_rst_wr", 1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 24'd0);
    step();
    drive(1'b0, 1'b0, 24'd0);
    check("post_rst_q", {8'd0, bus.q}, 32'h55AA55);
    check_flags("post_rst_rd", 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
